// File: rtl/mc_bus_bridge.sv
// MCU async parallel bus slave: synchronizes/filters ce/oe/we and issues single-cycle reg_wr/reg_rd
// requests. Optional MC_CE_GATE_EN gates strobes with chip enable. reg_wr 5 cycles after raw edge.
module mc_bus_bridge #(
  parameter int MC_ADD_WIDTH  = 6,
  parameter int MC_DATA_WIDTH = 16,
  parameter int FILTER_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  output logic [MC_ADD_WIDTH-1:0]  reg_addr,
  output logic [MC_DATA_WIDTH-1:0] reg_wdata,
  output logic                     reg_wr,
  output logic                     reg_rd,
  input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
  output logic                     bus_err
);

  localparam logic [3:0] FC = 4'(FILTER_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_PULSE = 3'd1,
    WR_HOLD  = 3'd2,
    RD_REQ   = 3'd3,
    RD_CAP   = 3'd4,
    RD_DRIVE = 3'd5
  } state_t;

  state_t     state, state_n;
  logic [1:0] we_sync, oe_sync;
  logic       we_s, oe_s;
  logic [3:0] we_cnt, oe_cnt;
  logic       acc_we, acc_oe;
  logic       ce_ok, ce_drop;
  logic [1:0] flush;
  logic       armed;
  logic       lat_wr, lat_rd, err_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_sync <= 2'b11;
      oe_sync <= 2'b11;
    end else begin
      we_sync <= {we_sync[0], mc_we};
      oe_sync <= {oe_sync[0], mc_oe};
    end
  end

  assign we_s = we_sync[1];
  assign oe_s = oe_sync[1];

`ifdef MC_CE_GATE_EN
  logic [1:0] ce_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ce_sync <= 2'b11;
    else        ce_sync <= {ce_sync[0], mc_ce};
  end

  assign ce_ok   = ~ce_sync[1];
  assign ce_drop = ce_sync[1];
`else
  logic unused_ce;

  assign unused_ce = mc_ce;
  assign ce_ok     = 1'b1;
  assign ce_drop   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_cnt <= 4'd0;
      oe_cnt <= 4'd0;
    end else begin
      if (we_s)              we_cnt <= 4'd0;
      else if (we_cnt != FC) we_cnt <= we_cnt + 4'd1;
      if (oe_s)              oe_cnt <= 4'd0;
      else if (oe_cnt != FC) oe_cnt <= oe_cnt + 4'd1;
    end
  end

  assign acc_we = (we_cnt == FC) && ce_ok;
  assign acc_oe = (oe_cnt == FC) && ce_ok;

  // The sync stages reset to "inactive", so they only reflect the pads two
  // cycles after release; arming waits for that so a held strobe is not seen high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush <= 2'b00;
      armed <= 1'b0;
    end else begin
      flush <= {flush[0], 1'b1};
      if (acc_we || acc_oe)             armed <= 1'b0;
      else if (flush[1] && we_s && oe_s) armed <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    lat_wr  = 1'b0;
    lat_rd  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (armed) begin
          if (acc_we && acc_oe) begin
            err_n = 1'b1;
          end else if (acc_we) begin
            lat_wr  = 1'b1;
            state_n = WR_PULSE;
          end else if (acc_oe) begin
            lat_rd  = 1'b1;
            state_n = RD_REQ;
          end
        end
      end
      WR_PULSE: state_n = WR_HOLD;
      WR_HOLD:  if (we_s || ce_drop) state_n = IDLE;
      RD_REQ:   state_n = RD_CAP;
      RD_CAP:   state_n = RD_DRIVE;
      RD_DRIVE: if (oe_s || ce_drop) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bus_err     <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      mc_data_out <= '0;
    end else begin
      state   <= state_n;
      bus_err <= err_n;
      if (lat_wr) begin
        reg_addr  <= mc_add;
        reg_wdata <= mc_data_in;
      end
      if (lat_rd)           reg_addr    <= mc_add;
      if (state == RD_CAP)  mc_data_out <= reg_rdata;
    end
  end

  assign reg_wr     = (state == WR_PULSE);
  assign reg_rd     = (state == RD_REQ);
  assign mc_data_oe = (state == RD_DRIVE);

endmodule

// File: tb/tb_mc_bus_bridge.sv
// Bench for mc_bus_bridge: vector table, multi-cycle corner sequences, and random
// transactions checked against a transaction-level model of the register file.
module tb_mc_bus_bridge;
  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        mc_ce, mc_oe, mc_we;
  logic [5:0]  mc_add;
  logic [15:0] mc_data_in, mc_data_out, reg_wdata, reg_rdata;
  logic        mc_data_oe, reg_wr, reg_rd, bus_err;
  logic [5:0]  reg_addr;

  always #5 clock = ~clock;

  mc_bus_bridge #(.MC_ADD_WIDTH(6), .MC_DATA_WIDTH(16), .FILTER_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
    .mc_add(mc_add), .mc_data_in(mc_data_in), .mc_data_out(mc_data_out),
    .mc_data_oe(mc_data_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .bus_err(bus_err)
  );

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0;
  logic [5:0]  wr_addr_log = '0, rd_addr_log = '0;
  logic [15:0] wr_data_log = '0, oe_data_log = '0;
  logic [15:0] rf [64];
  logic        rf_ready = 1'b0;
  logic [15:0] exp_rf [64];

  function automatic logic [15:0] seed_val(int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // Register file stand-in driven by the DUT's requests, plus event monitors.
  assign reg_rdata = rf[reg_addr];

  always @(negedge clock) begin
    if (!rf_ready) begin
      for (int i = 0; i < 64; i++) rf[i] = seed_val(i);
      rf_ready = 1'b1;
    end
    if (reg_wr) begin
      wr_cnt++;
      wr_addr_log = reg_addr;
      wr_data_log = reg_wdata;
      rf[reg_addr] = reg_wdata;
    end
    if (reg_rd) begin
      rd_cnt++;
      rd_addr_log = reg_addr;
    end
    if (bus_err) err_cnt++;
    if (mc_data_oe) begin
      oe_cnt++;
      oe_data_log = mc_data_out;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // kind: 0 = write, 1 = read, 2 = write and read strobes together
  task automatic drive(input int kind, input int len, input logic [5:0] a, input logic [15:0] d);
    @(negedge clock);
    mc_add = a;
    mc_data_in = d;
    if (kind == 0 || kind == 2) mc_we = 1'b0;
    if (kind == 1 || kind == 2) mc_oe = 1'b0;
    repeat (len) @(negedge clock);
    mc_we = 1'b1;
    mc_oe = 1'b1;
    repeat (14) @(negedge clock);
  endtask

  task automatic run_txn(input string nm, input int kind, input int len, input logic [5:0] a,
                         input logic [15:0] d, input int ew, input int er, input int ee,
                         input logic [15:0] v);
    int w0, r0, e0, o0;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cnt;
    drive(kind, len, a, d);
    check({nm, "_wr"}, wr_cnt - w0, ew);
    check({nm, "_rd"}, rd_cnt - r0, er);
    check({nm, "_err"}, err_cnt - e0, ee);
    if (ew != 0) begin
      check({nm, "_waddr"}, int'(wr_addr_log), int'(a));
      check({nm, "_wdata"}, int'(wr_data_log), int'(v));
      exp_rf[a] = v;
    end
    if (er != 0) begin
      check({nm, "_raddr"}, int'(rd_addr_log), int'(a));
      check({nm, "_oe_seen"}, int'(oe_cnt > o0), 1);
      check({nm, "_rdata"}, int'(oe_data_log), int'(v));
    end
  endtask

  typedef struct {
    int          kind;
    int          len;
    logic [5:0]  addr;
    logic [15:0] data;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int lat, seen, w0, r0, drop;

    vecs[0]  = '{0, 6, 6'h19, 16'h0003, 1, 0, 0, 16'h0003};
    vecs[1]  = '{0, 4, 6'h00, 16'h0055, 1, 0, 0, 16'h0055};
    vecs[2]  = '{0, 4, 6'h00, 16'h0020, 1, 0, 0, 16'h0020};
    vecs[3]  = '{0, 4, 6'h00, 16'h0202, 1, 0, 0, 16'h0202};
    vecs[4]  = '{0, 4, 6'h00, 16'h0103, 1, 0, 0, 16'h0103};
    vecs[5]  = '{1, 6, 6'h00, 16'h0000, 0, 1, 0, 16'h0103};
    vecs[6]  = '{0, 1, 6'h05, 16'hBEEF, 0, 0, 0, 16'h0000};
    vecs[7]  = '{2, 6, 6'h07, 16'h1111, 0, 0, 1, 16'h0000};
    vecs[8]  = '{0, 2, 6'h3F, 16'hA5A5, 1, 0, 0, 16'hA5A5};
    vecs[9]  = '{1, 3, 6'h3F, 16'h0000, 0, 1, 0, 16'hA5A5};
    vecs[10] = '{1, 1, 6'h19, 16'h0000, 0, 0, 0, 16'h0000};

    for (int i = 0; i < 64; i++) exp_rf[i] = seed_val(i);

    reset = 1'b0;
    mc_ce = 1'b0;
    mc_we = 1'b1;
    mc_oe = 1'b1;
    mc_add = '0;
    mc_data_in = '0;
    repeat (3) @(negedge clock);
    check("rst_reg_wr", int'(reg_wr), 0);
    check("rst_reg_rd", int'(reg_rd), 0);
    check("rst_bus_err", int'(bus_err), 0);
    check("rst_data_oe", int'(mc_data_oe), 0);
    check("rst_data_out", int'(mc_data_out), 0);
    check("rst_reg_addr", int'(reg_addr), 0);
    check("rst_reg_wdata", int'(reg_wdata), 0);
    reset = 1'b1;
    repeat (6) @(negedge clock);

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].kind, vecs[i].len, vecs[i].addr, vecs[i].data,
              vecs[i].exp_wr, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_val);

    // Write latency: reg_wr on the 5th cycle after the raw falling edge.
    w0 = wr_cnt;
    lat = -1;
    @(negedge clock);
    mc_add = 6'h19;
    mc_data_in = 16'h0003;
    mc_we = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (reg_wr === 1'b1 && lat < 0) lat = i;
      if (i == 6) mc_we = 1'b1;
    end
    check("wr_latency", lat, 5);
    check("wr_latency_cnt", wr_cnt - w0, 1);
    check("wr_latency_data", int'(wr_data_log), 16'h0003);
    exp_rf[6'h19] = 16'h0003;

    // Read: drive stays until one cycle after synced oe goes high.
    r0 = rd_cnt;
    seen = 0;
    @(negedge clock);
    mc_add = 6'h00;
    mc_oe = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clock);
      if (mc_data_oe === 1'b1) seen = 1;
    end
    check("rd_oe_asserted", seen, 1);
    repeat (2) @(negedge clock);
    check("rd_drive_data", int'(mc_data_out), 16'h0103);
    mc_oe = 1'b1;
    drop = -1;
    for (int i = 1; i <= 10 && drop < 0; i++) begin
      @(negedge clock);
      if (mc_data_oe === 1'b0) drop = i;
    end
    check("rd_oe_release", drop, 3);
    repeat (10) @(negedge clock);
    check("rd_req_cnt", rd_cnt - r0, 1);
    check("rd_data_hold", int'(mc_data_out), 16'h0103);

    // Reset while we is held low: the held strobe must not produce a write.
    w0 = wr_cnt;
    @(negedge clock);
    mc_add = 6'h2A;
    mc_data_in = 16'h1234;
    mc_we = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("arst_data_out", int'(mc_data_out), 0);
    check("arst_data_oe", int'(mc_data_oe), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    mc_we = 1'b1;
    repeat (14) @(negedge clock);
    check("arst_no_write", wr_cnt - w0, 0);
    run_txn("post_rst", 0, 6, 6'h2A, 16'h1234, 1, 0, 0, 16'h1234);

    // Random transactions against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      int kind, len, acc;
      logic [5:0]  a;
      logic [15:0] d, v;
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(1, 7));
      a    = 6'($urandom_range(0, 63));
      d    = 16'($urandom);
      acc  = (len >= FC) ? 1 : 0;
      v    = (kind == 0) ? d : exp_rf[a];
      run_txn($sformatf("rnd%0d", t), kind, len, a, d,
              (kind == 0) ? acc : 0, (kind == 1) ? acc : 0, (kind == 2) ? acc : 0, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

endmodule
